// File: rtl/ae_interp_sched_if.sv
// Bus bundle between the AE interpolation sequencer, its cell-map RAM and the
// bilinear interpolation unit.
interface ae_interp_sched_if #(
  parameter int unsigned AW = 8
) ();
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic [7:0]    interp_d0;
  logic [7:0]    interp_d1;
  logic [7:0]    interp_d2;
  logic [7:0]    interp_d3;
  logic [4:0]    interp_frac_w;
  logic [4:0]    interp_frac_h;
  logic          interp_vld;
  logic          interp_o_vld;

  modport master (
    output ram_rd, ram_addr,
    input  ram_data,
    output interp_d0, interp_d1, interp_d2, interp_d3,
    output interp_frac_w, interp_frac_h, interp_vld,
    input  interp_o_vld
  );

  modport slave (
    input  ram_rd, ram_addr,
    output ram_data,
    input  interp_d0, interp_d1, interp_d2, interp_d3,
    input  interp_frac_w, interp_frac_h, interp_vld,
    output interp_o_vld
  );
endinterface

// File: rtl/ae_interp_sched.sv
// AE bilinear interpolation sequencer: walks the output grid, fetches four cells per point
// and issues them to the interpolator. Optional cycle counter under AE_INTERP_SCHED_PERF_EN.
module ae_interp_sched #(
  parameter int unsigned CELL_W = 16,
  parameter int unsigned CELL_H = 12,
  parameter int unsigned OUT_W  = 64,
  parameter int unsigned OUT_H  = 48,
  parameter int unsigned AW     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  step_x,
  input  logic [9:0]  step_y,
  output logic        busy,
  output logic        done,
`ifdef AE_INTERP_SCHED_PERF_EN
  output logic [23:0] perf_cycles,
`endif
  ae_interp_sched_if.master bus
);

  localparam int unsigned OxW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned OyW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam logic [OxW-1:0] OxLast = OxW'(OUT_W - 1);
  localparam logic [OyW-1:0] OyLast = OyW'(OUT_H - 1);
  localparam logic [9:0]     XMax   = 10'(CELL_W - 1);
  localparam logic [9:0]     YMax   = 10'(CELL_H - 1);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StRd2, StRd3, StLast, StDrain} state_e;

  state_e         state_q, state_d;
  logic [9:0]     step_x_q, step_x_d, step_y_q, step_y_d;
  logic [14:0]    px_q, px_d, py_q, py_d;
  logic [OxW-1:0] ox_q, ox_d;
  logic [OyW-1:0] oy_q, oy_d;
  logic [7:0]     cap0_q, cap1_q, cap2_q;
  logic [7:0]     d0_q, d1_q, d2_q, d3_q;
  logic [4:0]     fw_q, fh_q;
  logic           vld_q;
  logic [2:0]     cnt_q;
  logic           issue;
  logic           dec;

  function automatic logic [14:0] sat_add(input logic [14:0] a, input logic [9:0] b);
    logic [15:0] s;
    s = {1'b0, a} + {6'b0, b};
    return s[15] ? 15'h7FFF : s[14:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [9:0] col, input logic [9:0] row);
    logic [31:0] lin;
    lin = 32'(row) * CELL_W + 32'(col);
    return lin[AW-1:0];
  endfunction

  // Neighbour decode with right/bottom edge clamping.
  logic       x_hi, y_hi;
  logic [9:0] ix, ix1, iy, iy1;
  assign x_hi = (px_q[14:5] >= XMax);
  assign y_hi = (py_q[14:5] >= YMax);
  assign ix   = x_hi ? XMax : px_q[14:5];
  assign ix1  = x_hi ? XMax : px_q[14:5] + 10'd1;
  assign iy   = y_hi ? YMax : py_q[14:5];
  assign iy1  = y_hi ? YMax : py_q[14:5] + 10'd1;

  always_comb begin
    state_d      = state_q;
    step_x_d     = step_x_q;
    step_y_d     = step_y_q;
    px_d         = px_q;
    py_d         = py_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    issue        = 1'b0;
    done         = 1'b0;
    busy         = (state_q != StIdle);
    bus.ram_rd   = 1'b0;
    bus.ram_addr = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRd0;
          step_x_d = step_x;
          step_y_d = step_y;
          px_d     = '0;
          py_d     = '0;
          ox_d     = '0;
          oy_d     = '0;
        end
      end
      StRd0: begin
        bus.ram_rd   = 1'b1;
        bus.ram_addr = cell_addr(ix, iy);
        state_d      = StRd1;
      end
      StRd1: begin
        bus.ram_rd   = 1'b1;
        bus.ram_addr = cell_addr(ix1, iy);
        state_d      = StRd2;
      end
      StRd2: begin
        bus.ram_rd   = 1'b1;
        bus.ram_addr = cell_addr(ix, iy1);
        state_d      = StRd3;
      end
      StRd3: begin
        bus.ram_rd   = 1'b1;
        bus.ram_addr = cell_addr(ix1, iy1);
        state_d      = StLast;
      end
      StLast: begin
        issue = 1'b1;
        if (ox_q != OxLast) begin
          ox_d = ox_q + 1'b1;
          px_d = sat_add(px_q, step_x_q);
        end else begin
          ox_d = '0;
          px_d = '0;
          oy_d = oy_q + 1'b1;
          py_d = sat_add(py_q, step_y_q);
        end
        state_d = (ox_q == OxLast && oy_q == OyLast) ? StDrain : StRd0;
      end
      StDrain: begin
        // The final issue may still be in the output register when DRAIN is entered.
        if (cnt_q == 3'd0 && !vld_q) begin
          done    = 1'b1;
          busy    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A result strobe with nothing outstanding is stale and must not underflow.
  assign dec = bus.interp_o_vld && (cnt_q != 3'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      step_x_q <= '0;
      step_y_q <= '0;
      px_q     <= '0;
      py_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      cap0_q   <= '0;
      cap1_q   <= '0;
      cap2_q   <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      d3_q     <= '0;
      fw_q     <= '0;
      fh_q     <= '0;
      vld_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
      px_q     <= px_d;
      py_q     <= py_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      if (state_q == StRd1) cap0_q <= bus.ram_data;
      if (state_q == StRd2) cap1_q <= bus.ram_data;
      if (state_q == StRd3) cap2_q <= bus.ram_data;
      vld_q <= issue;
      if (issue) begin
        d0_q <= cap0_q;
        d1_q <= cap1_q;
        d2_q <= cap2_q;
        d3_q <= bus.ram_data;
        fw_q <= px_q[4:0];
        fh_q <= py_q[4:0];
      end
      unique case ({vld_q, dec})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.interp_d0     = d0_q;
  assign bus.interp_d1     = d1_q;
  assign bus.interp_d2     = d2_q;
  assign bus.interp_d3     = d3_q;
  assign bus.interp_frac_w = fw_q;
  assign bus.interp_frac_h = fh_q;
  assign bus.interp_vld    = vld_q;

`ifdef AE_INTERP_SCHED_PERF_EN
  logic [23:0] perf_q;

  // Counts every non-idle cycle, including the done cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (state_q == StIdle) begin
      if (start) perf_q <= '0;
    end else if (perf_q != 24'hFF_FFFF) begin
      perf_q <= perf_q + 24'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_ae_interp_sched.sv
// Directed, table-driven bench for ae_interp_sched with a RAM model and a 6-cycle
// interpolator model (extra delay on the final point when requested).
module tb_ae_interp_sched;
  localparam int unsigned CW  = 16;
  localparam int unsigned CH  = 12;
  localparam int unsigned OW  = 16;
  localparam int unsigned OH  = 12;
  localparam int          NPT = OW * OH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] step_x = '0;
  logic [9:0] step_y = '0;
  logic       busy;
  logic       done;
`ifdef AE_INTERP_SCHED_PERF_EN
  logic [23:0] perf_cycles;
`endif

  ae_interp_sched_if #(.AW(8)) bus ();

  ae_interp_sched #(
    .CELL_W(CW),
    .CELL_H(CH),
    .OUT_W (OW),
    .OUT_H (OH),
    .AW    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .step_x     (step_x),
    .step_y     (step_y),
    .busy       (busy),
    .done       (done),
`ifdef AE_INTERP_SCHED_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int frame;
    int n;
    int a0, a1, a2, a3;
    int fw, fh;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad = 0;

  // Monitor / model state
  int         cyc = 0, k_start = 0, npts = 0, done_cnt = 0;
  int         done_cyc = -1, busy_fall = -1, ret_cyc = -1, extra_last = 0;
  bit         busy_prev = 1'b0, stray = 1'b0;
  int         due_q[$];
  logic       prev_rd = 1'b0;
  logic [7:0] prev_addr = '0;
  logic [7:0] cap_d0[NPT], cap_d1[NPT], cap_d2[NPT], cap_d3[NPT];
  logic [4:0] cap_fw[NPT], cap_fh[NPT];
  int         cap_off[NPT];

  function automatic logic [7:0] mem(input int a);
    logic [7:0] b;
    b = a[7:0];
    return b ^ 8'hA5;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // RAM with one-cycle read latency, interpolator with fixed latency, output monitor.
  initial begin
    bus.ram_data     = 8'h00;
    bus.interp_o_vld = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.ram_data = prev_rd ? mem(int'(prev_addr)) : 8'h00;
      prev_rd      = bus.ram_rd;
      prev_addr    = bus.ram_addr;
      bus.interp_o_vld = stray;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        bus.interp_o_vld = 1'b1;
        ret_cyc = cyc;
      end
      if (busy && !busy_prev) begin
        k_start  = cyc;
        npts     = 0;
        done_cyc = -1;
        busy_fall = -1;
      end
      if (!busy && busy_prev) busy_fall = cyc;
      if (bus.interp_vld) begin
        if (npts < NPT) begin
          cap_d0[npts]  = bus.interp_d0;
          cap_d1[npts]  = bus.interp_d1;
          cap_d2[npts]  = bus.interp_d2;
          cap_d3[npts]  = bus.interp_d3;
          cap_fw[npts]  = bus.interp_frac_w;
          cap_fh[npts]  = bus.interp_frac_h;
          cap_off[npts] = cyc - k_start + 1;
        end
        due_q.push_back(cyc + 6 + ((npts == NPT - 1) ? extra_last : 0));
        npts++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      busy_prev = busy;
    end
  end

  task automatic run_start(input logic [9:0] sx, input logic [9:0] sy);
    @(negedge clk);
    step_x = sx;
    step_y = sy;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int  d;
    bit  seen;
    d    = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic check_frame(input int f, input int exp_off);
    chk($sformatf("f%0d_done_off", f), done_cyc - k_start + 1, exp_off);
    chk($sformatf("f%0d_busy_fall", f), busy_fall, done_cyc);
    chk($sformatf("f%0d_ret_to_done", f), done_cyc - ret_cyc, 1);
    chk($sformatf("f%0d_points", f), npts, NPT);
    foreach (tbl[i]) begin
      if (tbl[i].frame == f) begin
        int n;
        n = tbl[i].n;
        chk($sformatf("f%0d_p%0d_d0", f, n), int'(cap_d0[n]), int'(mem(tbl[i].a0)));
        chk($sformatf("f%0d_p%0d_d1", f, n), int'(cap_d1[n]), int'(mem(tbl[i].a1)));
        chk($sformatf("f%0d_p%0d_d2", f, n), int'(cap_d2[n]), int'(mem(tbl[i].a2)));
        chk($sformatf("f%0d_p%0d_d3", f, n), int'(cap_d3[n]), int'(mem(tbl[i].a3)));
        chk($sformatf("f%0d_p%0d_fw", f, n), int'(cap_fw[n]), tbl[i].fw);
        chk($sformatf("f%0d_p%0d_fh", f, n), int'(cap_fh[n]), tbl[i].fh);
        chk($sformatf("f%0d_p%0d_off", f, n), cap_off[n], 5 * n + 6);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ram_rd"}, int'(bus.ram_rd), 0);
    chk({tag, "_ram_addr"}, int'(bus.ram_addr), 0);
    chk({tag, "_vld"}, int'(bus.interp_vld), 0);
    chk({tag, "_d"}, int'({bus.interp_d0, bus.interp_d1, bus.interp_d2, bus.interp_d3}), 0);
    chk({tag, "_frac"}, int'({bus.interp_frac_w, bus.interp_frac_h}), 0);
  endtask

  initial begin
    int dc;
    // frame, point, addr d0..d3, frac_w, frac_h
    tbl.push_back('{0, 0,   0,   1,   16,  17,  0,  0});
    tbl.push_back('{0, 17,  17,  18,  33,  34,  0,  0});
    tbl.push_back('{0, 15,  15,  15,  31,  31,  0,  0});
    tbl.push_back('{0, 176, 176, 177, 176, 177, 0,  0});
    tbl.push_back('{0, 191, 191, 191, 191, 191, 0,  0});
    tbl.push_back('{1, 0,   0,   1,   16,  17,  0,  0});
    tbl.push_back('{1, 1,   0,   1,   16,  17,  16, 0});
    tbl.push_back('{1, 2,   1,   2,   17,  18,  0,  0});
    tbl.push_back('{1, 3,   1,   2,   17,  18,  16, 0});
    tbl.push_back('{1, 21,  2,   3,   18,  19,  16, 8});
    tbl.push_back('{1, 191, 39,  40,  55,  56,  16, 24});
    tbl.push_back('{2, 0,   0,   1,   16,  17,  0,  0});
    tbl.push_back('{2, 1,   15,  15,  31,  31,  31, 0});
    tbl.push_back('{2, 16,  176, 177, 176, 177, 0,  31});
    tbl.push_back('{2, 191, 191, 191, 191, 191, 17, 21});
    tbl.push_back('{3, 0,   0,   1,   16,  17,  0,  0});
    tbl.push_back('{3, 100, 0,   1,   16,  17,  0,  0});
    tbl.push_back('{3, 191, 0,   1,   16,  17,  0,  0});
    tbl.push_back('{4, 0,   0,   1,   16,  17,  0,  0});
    tbl.push_back('{4, 10,  10,  11,  26,  27,  0,  0});
    tbl.push_back('{4, 191, 191, 191, 191, 191, 0,  0});
    tbl.push_back('{5, 37,  37,  38,  53,  54,  0,  0});
    tbl.push_back('{5, 191, 191, 191, 191, 191, 0,  0});

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Identity scaling
    run_start(10'h020, 10'h020);
    wait_done(1500);
    check_frame(0, 968);
    dc = done_cnt;
    repeat (5) @(negedge clk);
    chk("done_single_pulse", done_cnt - dc, 0);
`ifdef AE_INTERP_SCHED_PERF_EN
    chk("perf_cycles_hold", int'(perf_cycles), 968);
`endif

    // Fractional step, with a conflicting start in RD2 that must be ignored
    run_start(10'h010, 10'h008);
    repeat (2) @(negedge clk);
    step_x = 10'h020;
    step_y = 10'h3FF;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(1500);
    check_frame(1, 968);

    // Clamp at right and bottom edges
    run_start(10'h3FF, 10'h3FF);
    wait_done(1500);
    check_frame(2, 968);

    // Zero step
    run_start(10'h000, 10'h000);
    wait_done(1500);
    check_frame(3, 968);

    // Reset mid-frame, then stray result strobes while idle
    run_start(10'h020, 10'h020);
    for (int i = 0; i < 200 && npts < 11; i++) @(negedge clk);
    chk("abort_reached_point10", npts, 11);
    dc = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("abort");
`ifdef AE_INTERP_SCHED_PERF_EN
    chk("perf_cycles_reset", int'(perf_cycles), 0);
`endif
    repeat (3) begin
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", done_cnt - dc, 0);

    run_start(10'h020, 10'h020);
    wait_done(1500);
    check_frame(4, 968);

    // Drain: final result returns 20 cycles late
    extra_last = 20;
    run_start(10'h020, 10'h020);
    wait_done(1500);
    check_frame(5, 988);
    extra_last = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ae_interp_sched.md
# ae_interp_sched

Sequencer for the AE bilinear interpolation datapath. On `start` it walks an OUT_W×OUT_H output grid and maps each point to a fixed-point source position on a CELL_W×CELL_H AE cell map. It reads the four neighbouring cells from the cell-map RAM, then issues them with `frac_h`/`frac_w` to the interpolation unit. It tracks in-flight results and signals frame completion once every interpolated sample has returned.

## Interface
Parameters:
- CELL_W, 16, cell-map width in cells (≥2)
- CELL_H, 12, cell-map height in cells (≥2)
- OUT_W, 64, output points per row
- OUT_H, 48, output rows
- AW, 8, RAM address width; CELL_W*CELL_H ≤ 2^AW

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- start  in  1  frame start pulse
- step_x  in  10  source step per output column, unsigned 5.5 fixed point
- step_y  in  10  source step per output row, unsigned 5.5 fixed point
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- ram_rd  out  1  cell-map read strobe
- ram_addr  out  AW  cell address = row*CELL_W + col
- ram_data  in  8  read data, valid the cycle after ram_rd
- interp_d0..interp_d3  out  8 each  cells (ix,iy), (ix1,iy), (ix,iy1), (ix1,iy1)
- interp_frac_w  out  5  horizontal fraction
- interp_frac_h  out  5  vertical fraction
- interp_vld  out  1  issue strobe to interpolator
- interp_o_vld  in  1  result strobe from interpolator

## Operation
- States: IDLE, RD0, RD1, RD2, RD3, LAST, DRAIN.
- IDLE:
  - `start` latches step_x/step_y and clears the position accumulators px, py (15 bits, 10.5) and ox, oy.
  - The FSM then goes to RD0.
  - `start` outside IDLE is ignored.
- Position decode:
  - ix = px[14:5], fw = px[4:0]; iy = py[14:5], fh = py[4:0].
  - If ix ≥ CELL_W-1, then ix = ix1 = CELL_W-1; otherwise ix1 = ix+1.
  - iy/iy1 clamp the same way against CELL_H-1.
  - Fractions are passed unmodified.
- Reads: RD0..RD3 drive ram_rd=1 with the addresses of d0..d3 in order. Data is captured one cycle later, in RD1, RD2, RD3 and LAST.
- LAST:
  - Captures d3 and advances the position.
  - If ox < OUT_W-1: ox++ and px += step_x.
  - Otherwise: ox = 0, px = 0, oy++ and py += step_y.
  - Goes to RD0, or to DRAIN after point (OUT_W-1, OUT_H-1).
- Issue: interp_vld is registered high for exactly one cycle following each LAST, with d0..d3 and the fractions stable in that cycle. Data outputs hold their value otherwise.
- Outstanding counter (3 bits):
  - Increments on interp_vld and decrements on interp_o_vld.
  - Simultaneous increment and decrement leave it unchanged.
  - interp_o_vld with the counter at 0 is ignored, with no underflow.
- DRAIN: when the counter reaches 0, the FSM pulses done and returns to IDLE. busy drops in the same cycle as done.
- Arithmetic: accumulators saturate at 15'h7FFF (no wrap). step = 0 produces every point from cell column/row 0 with frac 0.

## Timing
- Reset values: busy=0, done=0, ram_rd=0, ram_addr=0, interp_vld=0, interp_d*=0, interp_frac_*=0. The FSM goes to IDLE and the counter clears.
- rst_n low mid-frame aborts immediately. Late interp_o_vld pulses that arrive afterwards are ignored.
- `start` sampled at edge k: RD0 runs in cycle k+1.
- Throughput: one point per 5 cycles. The nth point (0-based) has interp_vld at cycle k+5n+6.
- With the 6-cycle interpolator, done occurs at cycle k+5N+8, where N = OUT_W*OUT_H. In general, done follows the last interp_o_vld by 1 cycle.
- At most 2 results are in flight.

## Configuration
- AE_INTERP_SCHED_PERF_EN defined:
  - Adds output `perf_cycles` (24 bits).
  - It clears on an accepted start, counts every busy cycle and saturates at all-ones.
  - It holds its value after done and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Identity scaling: CELL 16×12, OUT 16×12, step_x=step_y=10'h020 → point (x,y) reads addresses y*16+x, y*16+x+1, etc., with fractions 0. done at k+5·192+8.
- Fractional step: step_x=10'h010, OUT_W 4, one row → ix sequence 0,0,1,1 and fw 0,16,0,16; address pairs (0,1),(0,1),(1,2),(1,2).
- Right/bottom clamp: a step driving ix to CELL_W-1 (15) → d0 and d1 addresses are equal, both 15+row*16; iy=11 gives d2 and d3 on row 11.
- Start during busy and reset mid-frame: a second start at RD2 is ignored. rst_n low for 1 cycle at point 10 returns all outputs to 0 with no done. A later start runs a full frame correctly despite stray interp_o_vld pulses.
- Drain: delay interp_o_vld for the final point by 20 cycles → busy stays 1 and done pulses exactly 1 cycle after that strobe.
- PERF_EN build: OUT 2×2 identity → perf_cycles = 28 after done.
